// File: rtl/dsp_mac_sequencer.sv
// Valid/ready front end and result collector for a DSP48A1 slice (all pipeline regs = 1),
// producing one 48-bit dot-product per vector. Optional bias via C: MAC_SEQ_BIAS_EN.
module dsp_mac_sequencer #(
    parameter int DSP_LAT = 4,
    parameter int OPM_DLY = 2,
    parameter int LEN_W   = 10
) (
    input  logic                 clk,
    input  logic                 RSTN,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [17:0]   s_a,
    input  logic signed [17:0]   s_b,
    input  logic                 s_last,
`ifdef MAC_SEQ_BIAS_EN
    input  logic signed [47:0]   s_bias,
`endif
    output logic signed [17:0]   dsp_a,
    output logic signed [17:0]   dsp_b,
    output logic signed [17:0]   dsp_d,
    output logic signed [47:0]   dsp_c,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_carryin,
    output logic                 dsp_ce,
    input  logic signed [47:0]   dsp_p,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [47:0]   m_result,
    output logic [LEN_W:0]       m_len
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam int             DW        = $clog2(DSP_LAT + 1);
    localparam logic [DW-1:0]  DRAIN_END = DW'(DSP_LAT);
    localparam logic [LEN_W:0] LEN_ONE   = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] LEN_MAX   = {1'b1, {LEN_W{1'b0}}};
    localparam logic [7:0]     OPM_ZERO  = 8'b0000_0000;
    localparam logic [7:0]     OPM_HOLD  = 8'b0000_1000;
    localparam logic [7:0]     OPM_ACC   = 8'b0000_1001;
`ifdef MAC_SEQ_BIAS_EN
    localparam logic [7:0]     OPM_FIRST = 8'b0000_1101;
`else
    localparam logic [7:0]     OPM_FIRST = 8'b0000_0001;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_ready;
    logic                  w_hs;
    logic                  w_capture;
    logic [7:0]            w_opm_code;
    logic                  r_ce;
    logic signed [17:0]    r_dsp_a_p0;
    logic signed [17:0]    r_dsp_b_p0;
    logic [7:0]            r_opm_dly [0:OPM_DLY];
    logic [LEN_W:0]        r_cnt;
    logic [DW-1:0]         r_drain_cnt;
    logic                  r_m_valid;
    logic signed [47:0]    r_m_result;
    logic [LEN_W:0]        r_m_len;

    // Element count saturates at 2^LEN_W; extra elements are still accumulated.
    function automatic logic [LEN_W:0] sat_inc(input logic [LEN_W:0] cnt);
        if (cnt == LEN_MAX)
            return LEN_MAX;
        return cnt + LEN_ONE;
    endfunction

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = s_last ? DRAIN : ACCUM;
            ACCUM:   if (w_hs && s_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_capture) w_state_nxt = OUT;
            OUT:     if (r_m_valid && m_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bubbles inside a vector and during the drain hold P (X=0, Z=P).
    always_comb begin
        w_ready    = 1'b0;
        w_hs       = 1'b0;
        w_capture  = 1'b0;
        w_opm_code = OPM_ZERO;
        case (r_state)
            IDLE: begin
                w_ready    = r_ce;
                w_hs       = s_valid & r_ce;
                w_opm_code = (s_valid & r_ce) ? OPM_FIRST : OPM_ZERO;
            end
            ACCUM: begin
                w_ready    = r_ce;
                w_hs       = s_valid & r_ce;
                w_opm_code = (s_valid & r_ce) ? OPM_ACC : OPM_HOLD;
            end
            DRAIN: begin
                w_opm_code = OPM_HOLD;
                w_capture  = (r_drain_cnt == DRAIN_END);
            end
            default: ;
        endcase
    end

    // p0: operands and OPMODE code registered at the handshake; OPMODE then delayed
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_ce        <= 1'b0;
            r_dsp_a_p0  <= '0;
            r_dsp_b_p0  <= '0;
            for (int i = 0; i <= OPM_DLY; i++)
                r_opm_dly[i] <= '0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_m_valid   <= 1'b0;
            r_m_result  <= '0;
            r_m_len     <= '0;
        end else begin
            r_ce        <= 1'b1;
            r_dsp_a_p0  <= w_hs ? s_a : 18'sd0;
            r_dsp_b_p0  <= w_hs ? s_b : 18'sd0;
            r_opm_dly[0] <= w_opm_code;
            for (int i = 1; i <= OPM_DLY; i++)
                r_opm_dly[i] <= r_opm_dly[i-1];
            if (w_hs)
                r_cnt <= (r_state == IDLE) ? LEN_ONE : sat_inc(r_cnt);
            if (w_hs && s_last)
                r_drain_cnt <= '0;
            else if (r_state == DRAIN)
                r_drain_cnt <= r_drain_cnt + 1'b1;
            if (w_capture) begin
                r_m_valid  <= 1'b1;
                r_m_result <= dsp_p;
                r_m_len    <= r_cnt;
            end else if (r_m_valid && m_ready) begin
                r_m_valid  <= 1'b0;
            end
        end
    end

`ifdef MAC_SEQ_BIAS_EN
    logic signed [47:0] r_dsp_c;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN)
            r_dsp_c <= '0;
        else if (w_hs && r_state == IDLE)
            r_dsp_c <= s_bias;
    end

    assign dsp_c = r_dsp_c;
`else
    assign dsp_c = '0;
`endif

    assign s_ready     = w_ready;
    assign dsp_a       = r_dsp_a_p0;
    assign dsp_b       = r_dsp_b_p0;
    assign dsp_d       = '0;
    assign dsp_opmode  = r_opm_dly[OPM_DLY];
    assign dsp_carryin = 1'b0;
    assign dsp_ce      = r_ce;
    assign m_valid     = r_m_valid;
    assign m_result    = r_m_result;
    assign m_len       = r_m_len;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: DSP48A1 slice model plus a vector-level dot-product
// reference; optional bias tests follow MAC_SEQ_BIAS_EN.
module tb_dsp_mac_sequencer;
    localparam int DSP_LAT = 4;
    localparam int OPM_DLY = 2;
    localparam int LEN_W   = 10;
    localparam int LEN_CAP = 1 << LEN_W;

    logic                 clk = 1'b0;
    logic                 RSTN = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [17:0]   s_a = '0;
    logic signed [17:0]   s_b = '0;
    logic                 s_last = 1'b0;
    logic signed [47:0]   s_bias = '0;
    logic signed [17:0]   dsp_a, dsp_b, dsp_d;
    logic signed [47:0]   dsp_c;
    logic [7:0]           dsp_opmode;
    logic                 dsp_carryin, dsp_ce;
    logic signed [47:0]   dsp_p;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [47:0]   m_result;
    logic [LEN_W:0]       m_len;

    dsp_mac_sequencer #(.DSP_LAT(DSP_LAT), .OPM_DLY(OPM_DLY), .LEN_W(LEN_W)) dut (
        .clk(clk), .RSTN(RSTN), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last),
`ifdef MAC_SEQ_BIAS_EN
        .s_bias(s_bias),
`endif
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce),
        .dsp_p(dsp_p), .m_valid(m_valid), .m_ready(m_ready),
        .m_result(m_result), .m_len(m_len)
    );

    always #5 clk = ~clk;

    // DSP48A1 slice: A0/A1, B0/B1, C, M, OPMODE and P registers, common CE
    logic signed [17:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic signed [35:0] mreg = '0;
    logic [7:0]         opreg = '0;
    logic signed [47:0] creg = '0, preg = '0;
    logic signed [47:0] xmux, zmux, cin;

    always_comb begin
        case (opreg[1:0])
            2'd0:    xmux = '0;
            2'd1:    xmux = {{12{mreg[35]}}, mreg};
            2'd2:    xmux = preg;
            default: xmux = {dsp_d[11:0], a1, b1};
        endcase
        case (opreg[3:2])
            2'd0:    zmux = '0;
            2'd1:    zmux = '0;
            2'd2:    zmux = preg;
            default: zmux = creg;
        endcase
        cin = {47'd0, opreg[5]};
    end

    always @(posedge clk) begin
        if (dsp_ce) begin
            a0    <= dsp_a;
            a1    <= a0;
            b0    <= dsp_b;
            b1    <= b0;
            mreg  <= a1 * b1;
            opreg <= dsp_opmode;
            creg  <= dsp_c;
            preg  <= opreg[7] ? (zmux - (xmux + cin)) : (zmux + xmux + cin);
        end
    end
    assign dsp_p = preg;

    int n_checks = 0;
    int n_fail   = 0;
    int tmo_req  = 0;
    int tmo_seen = 0;
    int post_cnt = 0;
    bit rand_mr = 1'b0;
    logic m_ready_dir = 1'b1;

    typedef struct {
        logic signed [47:0] res;
        logic [LEN_W:0]     len;
        bit                 has_lit;
        logic signed [47:0] lit_res;
        logic [LEN_W:0]     lit_len;
    } exp_t;

    exp_t               expq[$];
    logic signed [47:0] acc = '0;
    int                 cnt = 0;
    bit                 in_vec = 1'b0, busy = 1'b0, out_seen = 1'b0;
    int                 wait_cyc = 0;
    logic signed [17:0] exp_a = '0, exp_b = '0;
    bit                 lit_valid = 1'b0;
    logic signed [47:0] lit_res = '0;
    logic [LEN_W:0]     lit_len = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge RSTN) begin
        if (!RSTN)
            post_cnt <= 0;
        else if (post_cnt < 3)
            post_cnt <= post_cnt + 1;
    end

    always @(posedge clk) begin
        #1;
        m_ready = rand_mr ? ($urandom_range(0, 2) != 0) : m_ready_dir;
    end

    // Single compare process: checks first, then advances the reference with this cycle's handshake
    always @(negedge clk) begin
        logic signed [47:0] prod;
        exp_t e;
        if (!RSTN) begin
            chk("reset_s_ready",  64'(s_ready),  64'(0));
            chk("reset_m_valid",  64'(m_valid),  64'(0));
            chk("reset_m_result", 64'(m_result), 64'(0));
            chk("reset_m_len",    64'(m_len),    64'(0));
            chk("reset_dsp_ce",   64'(dsp_ce),   64'(0));
            chk("reset_dsp_drv",  64'({dsp_a, dsp_b, dsp_opmode}), 64'(0));
            expq.delete();
            in_vec = 1'b0; busy = 1'b0; out_seen = 1'b0; exp_a = '0; exp_b = '0;
        end else begin
            chk("dsp_a", 64'(dsp_a), 64'(exp_a));
            chk("dsp_b", 64'(dsp_b), 64'(exp_b));
            if (post_cnt >= 1) begin
                chk("dsp_const", 64'({dsp_d, dsp_carryin, dsp_opmode[7:4]}), 64'(0));
                chk("dsp_ce", 64'(dsp_ce), 64'(1));
                chk("s_ready", 64'(s_ready), 64'(!busy));
            end
`ifndef MAC_SEQ_BIAS_EN
            chk("dsp_c_zero", 64'(dsp_c), 64'(0));
`endif
            if (tmo_req != tmo_seen) begin
                chk("bounded_wait", 64'(tmo_req), 64'(tmo_seen));
                tmo_seen = tmo_req;
            end
            if (busy) begin
                if (!out_seen) begin
                    wait_cyc++;
                    if (wait_cyc <= DSP_LAT + 2)
                        chk("m_valid_latency", 64'(m_valid), 64'(wait_cyc == DSP_LAT + 2));
                    out_seen = m_valid;
                end else begin
                    chk("m_valid_hold", 64'(m_valid), 64'(1));
                end
                if (m_valid) begin
                    e = expq[0];
                    chk("m_result", 64'(m_result), 64'(e.res));
                    chk("m_len",    64'(m_len),    64'(e.len));
                    if (e.has_lit) begin
                        chk("m_result_literal", 64'(m_result), 64'(e.lit_res));
                        chk("m_len_literal",    64'(m_len),    64'(e.lit_len));
                    end
                    if (m_ready) begin
                        void'(expq.pop_front());
                        busy = 1'b0;
                        out_seen = 1'b0;
                    end
                end
            end else begin
                chk("m_valid_idle", 64'(m_valid), 64'(0));
            end
            exp_a = '0;
            exp_b = '0;
            if (s_valid && s_ready) begin
                prod  = s_a * s_b;
                exp_a = s_a;
                exp_b = s_b;
                if (!in_vec) begin
                    acc = s_bias + prod;
                    cnt = 1;
                    in_vec = 1'b1;
                end else begin
                    acc = acc + prod;
                    cnt++;
                end
                if (s_last) begin
                    e.res     = acc;
                    e.len     = (LEN_W + 1)'((cnt > LEN_CAP) ? LEN_CAP : cnt);
                    e.has_lit = lit_valid;
                    e.lit_res = lit_res;
                    e.lit_len = lit_len;
                    expq.push_back(e);
                    in_vec = 1'b0; busy = 1'b1; out_seen = 1'b0; wait_cyc = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [17:0] a, input logic signed [17:0] b,
                        input bit last, input int gap);
        int  guard;
        bit  hs;
        guard = 0;
        hs = 1'b0;
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        while (!hs) begin
            @(negedge clk);
            hs = s_ready;
            cyc();
            guard++;
            if (!hs && guard > 400) begin
                tmo_req++;
                break;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        s_a = 18'($urandom); s_b = 18'($urandom);
        repeat (gap) cyc();
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (busy) tmo_req++;
        cyc();
    endtask

    task automatic set_lit(input logic signed [47:0] r, input int l);
        lit_valid = 1'b1;
        lit_res   = r;
        lit_len   = (LEN_W + 1)'(l);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int len;
        int g;
        // Reset with random upstream traffic
        RSTN = 1'b0;
        repeat (6) begin
            cyc();
            s_valid = 1'($urandom); s_a = 18'($urandom); s_b = 18'($urandom); s_last = 1'($urandom);
        end
        s_valid = 1'b0; s_last = 1'b0;
        cyc();
        RSTN = 1'b1;
        cyc();

        set_lit(48'sd44, 3);
        send(18'sd1, 18'sd2, 1'b0, 0);
        send(18'sd3, 18'sd4, 1'b0, 0);
        send(18'sd5, 18'sd6, 1'b1, 0);
        wait_idle();

        // Bubbles between beats and a stalled consumer
        m_ready_dir = 1'b0;
        send(18'sd1, 18'sd2, 1'b0, 2);
        send(18'sd3, 18'sd4, 1'b0, 2);
        send(18'sd5, 18'sd6, 1'b1, 0);
        g = 0;
        while (!m_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!m_valid) tmo_req++;
        repeat (5) cyc();
        m_ready_dir = 1'b1;
        wait_idle();

        set_lit(-48'sd21, 1);
        send(-18'sd3, 18'sd7, 1'b1, 0);
        set_lit(48'sd8, 2);
        send(18'sd2, 18'sd2, 1'b0, 0);
        send(18'sd2, 18'sd2, 1'b1, 0);
        wait_idle();

        // Reset two cycles into the drain: the partial sum must vanish
        lit_valid = 1'b0;
        send(18'sd10, 18'sd10, 1'b0, 0);
        send(18'sd10, 18'sd10, 1'b1, 0);
        repeat (2) cyc();
        RSTN = 1'b0;
        repeat (2) cyc();
        RSTN = 1'b1;
        cyc();
        set_lit(48'sd1, 1);
        send(18'sd1, 18'sd1, 1'b1, 0);
        wait_idle();

`ifdef MAC_SEQ_BIAS_EN
        s_bias = 48'sd100;
        set_lit(48'sd126, 2);
        send(18'sd2, 18'sd3, 1'b0, 0);
        s_bias = 48'sd999;
        send(18'sd4, 18'sd5, 1'b1, 0);
        wait_idle();
        s_bias = 48'sd0;
        set_lit(48'sd1, 1);
        send(18'sd1, 18'sd1, 1'b1, 0);
        wait_idle();
`endif

        // Count saturation at 2^LEN_W while the sum keeps accumulating
        set_lit(48'sd1030, LEN_CAP);
        for (int k = 0; k < 1030; k++)
            send(18'sd1, 18'sd1, k == 1029, 0);
        wait_idle();

        lit_valid = 1'b0;
        rand_mr = 1'b1;
        for (int v = 0; v < 20; v++) begin
            len = $urandom_range(1, 8);
`ifdef MAC_SEQ_BIAS_EN
            s_bias = {16'($urandom), 32'($urandom)};
`endif
            for (int k = 0; k < len; k++)
                send(18'($urandom), 18'($urandom), k == len - 1, $urandom_range(0, 2));
        end
        wait_idle();
        rand_mr = 1'b0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
